// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_unit
// Purpose  : LIFO stack with DEPTH x DATA_W storage and a single count
//            pointer. Supports push, pop, simultaneous push+pop (replace top,
//            or pass-through when empty), registered pop data with a
//            one-cycle valid pulse, and overflow/underflow error flags.
// Options  : STACK_ERR_STICKY_EN - error flags hold until err_clr instead of
//            pulsing for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module stack_unit #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int BASE_ADDR = 8,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              err_clr,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [31:0]       sp,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_pop_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_mem_idx;
  logic              w_mem_we;
  logic              w_ovf_evt;
  logic              w_udf_evt;

  // Status is a pure function of the count register.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_top_idx = IDX_W'(r_count - 1'b1);

  // Push alone writes the next free slot; push+pop overwrites the top.
  // An empty push+pop is a pass-through and touches no storage.
  assign w_mem_we  = push & (pop ? ~w_empty : ~w_full);
  assign w_mem_idx = pop ? w_top_idx : r_count[IDX_W-1:0];

  // Only one-sided operations can be refused.
  assign w_ovf_evt = push & ~pop & w_full;
  assign w_udf_evt = pop & ~push & w_empty;

`ifndef STACK_ERR_STICKY_EN
  // err_clr has no effect when flags are pulses.
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
`endif

  // Storage write; contents are intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= push_data;
    end
  end

  // Pointer, pop data path and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      if (push && pop) begin
        r_pop_valid <= 1'b1;
        r_pop_data  <= w_empty ? push_data : r_mem[w_top_idx];
      end else if (push) begin
        if (!w_full) begin
          r_count <= r_count + 1'b1;
        end
      end else if (pop) begin
        if (!w_empty) begin
          r_pop_data  <= r_mem[w_top_idx];
          r_count     <= r_count - 1'b1;
          r_pop_valid <= 1'b1;
        end
      end

`ifdef STACK_ERR_STICKY_EN
      // A new event wins over a simultaneous clear.
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_evt) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
`else
      r_overflow  <= w_ovf_evt;
      r_underflow <= w_udf_evt;
`endif
    end
  end

  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign sp        = 32'(BASE_ADDR) + 32'(r_count);
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the stack entry width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of stack entries (power of two, >=2).
REQ-003 The block SHALL have parameter BASE_ADDR, default 8, meaning the word address reported by sp when the stack is empty.
REQ-004 The block SHALL have local parameter CNT_W = clog2(DEPTH)+1, meaning the width of count.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port push, input, 1 bit: write push_data onto the stack this cycle.
REQ-008 The block SHALL have port pop, input, 1 bit: remove the top entry this cycle.
REQ-009 The block SHALL have port push_data, input, DATA_W bits: the data to push.
REQ-010 The block SHALL have port err_clr, input, 1 bit: clear the error flags.
REQ-011 The block SHALL have port pop_data, output, DATA_W bits: the popped entry, registered.
REQ-012 The block SHALL have port pop_valid, output, 1 bit: pop_data is updated this cycle.
REQ-013 The block SHALL have port sp, output, 32 bits: BASE_ADDR + count.
REQ-014 The block SHALL have port count, output, CNT_W bits: the number of valid entries, 0..DEPTH.
REQ-015 The block SHALL have ports full and empty, output, 1 bit each: full is count==DEPTH; empty is count==0.
REQ-016 The block SHALL have ports overflow and underflow, output, 1 bit each: push refused; pop refused.

Function
REQ-017 The block SHALL hold DEPTH x DATA_W internal storage, with count as the only pointer; the top of stack is entry count-1.
REQ-018 On push only, when not full, the block SHALL write mem[count] <= push_data and set count <= count+1, both on the same edge.
REQ-019 On push only, when full, storage and count SHALL be unchanged and an overflow event SHALL be raised.
REQ-020 On pop only, when not empty, the block SHALL set pop_data <= mem[count-1], count <= count-1, and pulse pop_valid high for exactly the following cycle (1-cycle latency).
REQ-021 On pop only, when empty, count and pop_data SHALL be unchanged, pop_valid SHALL stay 0, and an underflow event SHALL be raised.
REQ-022 On push and pop together, when not empty, the block SHALL replace the top entry: pop_data <= old mem[count-1], mem[count-1] <= push_data, count unchanged, pop_valid pulses, and no error is raised.
REQ-023 On push and pop together, when empty, the block SHALL pass through: pop_data <= push_data, pop_valid pulses, count stays 0, and no error is raised, including when DEPTH entries are full-boundary irrelevant.
REQ-024 With neither push nor pop, all state SHALL hold and pop_valid SHALL be 0.
REQ-025 sp, full and empty SHALL derive combinationally from the count register only, so they update on the same edge as count.
REQ-026 count SHALL never exceed DEPTH or wrap below 0.

Reset
REQ-027 While rst=0, asynchronously, the block SHALL set count=0 (sp=BASE_ADDR, empty=1, full=0), pop_data=0, pop_valid=0, overflow=0 and underflow=0; storage contents are not reset.
REQ-028 A reset asserted mid-operation SHALL abort any push or pop in that cycle; the first operation after rst rises SHALL be evaluated against count=0.

Configuration
REQ-029 The block SHALL support macro STACK_ERR_STICKY_EN.
REQ-030 With STACK_ERR_STICKY_EN defined, overflow and underflow SHALL set on their event and hold until err_clr=1 is sampled; if err_clr and a new event occur in the same cycle, the flag SHALL remain set.
REQ-031 With STACK_ERR_STICKY_EN undefined, overflow and underflow SHALL be single-cycle registered pulses in the cycle after the event, and err_clr SHALL be ignored.

Verification (DEPTH=8, BASE_ADDR=8, DATA_W=32)
REQ-032 Reset, then push 0x11,0x22,0x33 -> count=3, sp=11; pop -> next cycle pop_data=0x33, pop_valid=1, count=2, sp=10.
REQ-033 9 pushes of 0x1..0x9 -> after the 8th push full=1, sp=16; the 9th raises overflow, count stays 8; 8 pops return 0x8..0x1 in order.
REQ-034 Pop on an empty stack -> underflow=1, pop_valid=0, count=0, sp=8; with STACK_ERR_STICKY_EN the flag holds until err_clr, and without it the flag is a 1-cycle pulse.
REQ-035 Stack holding 0xA,0xB, push 0xC with pop together -> pop_data=0xB, count=2, top becomes 0xC; on an empty stack, push 0x5 with pop -> pop_data=0x5, count=0, no error.
REQ-036 Push 0x1,0x2, then assert rst low between clock edges -> count=0, sp=8, pop_valid=0 immediately; after release, pop -> underflow.
